// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared LC-3b fetch/predict types for the BTB slice
package branch_target_buffer_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [4:0]  lc3b_p_index;
    typedef logic [9:0]  lc3b_btb_tag;

    // One in-flight prediction: the fetched PC and the next PC we guessed for it.
    typedef struct packed {
        lc3b_word pc;
        lc3b_word pred_next;
    } lc3b_pred_entry;

    localparam int PRED_FIFO_DEPTH = 4;
    localparam int BTB_ENTRIES     = 1 << $bits(lc3b_p_index);

endpackage

// File: rtl/branch_target_buffer_pred_fifo.sv
// rtl/branch_target_buffer_pred_fifo.sv - in-order FIFO of outstanding predictions
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, push_data  enqueue one lc3b_pred_entry
//   pop              dequeue the head entry
//   flush            empty the FIFO next cycle, overriding push/pop
//   head             oldest entry (valid when !empty)
//   count/full/empty occupancy status
module pred_fifo
    import branch_target_buffer_pkg::*;
#(
    parameter int DEPTH = PRED_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  lc3b_pred_entry push_data,
    input  logic           pop,
    input  logic           flush,
    output lc3b_pred_entry head,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty
);

    lc3b_pred_entry r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged, even when full.
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with in-order prediction tracking
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_pc/fetch_valid       instruction presented by fetch; fetch_ready accepts it
//   pred_index/branch_count    read index to the bimodal counters and returned count
//   pred_taken/next_pc         prediction for fetch_pc (combinational)
//   res_*                      resolution of the oldest in-flight instruction from EX
//   mispredict/redirect_pc     flush request and the correct next PC
//   upd_en/upd_index/upd_taken counter update request for conditional branches
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES    = BTB_ENTRIES,
    parameter int FIFO_DEPTH = PRED_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fetch_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    output logic [4:0]  pred_index,
    input  logic [1:0]  branch_count,
    output logic        pred_taken,
    output logic [15:0] next_pc,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic        res_is_branch,
    input  logic        res_is_cond,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    output logic        mispredict,
    output logic [15:0] redirect_pc,
    output logic        upd_en,
    output logic [4:0]  upd_index,
    output logic        upd_taken
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_uncond;
    lc3b_btb_tag        r_tag    [ENTRIES];
    lc3b_word           r_target [ENTRIES];

    lc3b_p_index    w_fetch_idx;
    lc3b_btb_tag    w_fetch_tag;
    logic           w_hit;
    lc3b_p_index    w_res_idx;
    lc3b_word       w_actual_next;
    logic           w_push;
    logic           w_pop;
    logic           w_btb_write;
    lc3b_pred_entry w_push_data;
    lc3b_pred_entry w_head;
    logic [CW-1:0]  w_unused_count;
    logic           w_full;
    logic           w_empty;
    logic           w_unused_bits;

    // Lookup: a hit on an unconditional entry is always taken; a conditional
    // entry follows the counter's direction bit.
    assign w_fetch_idx = fetch_pc[5:1];
    assign w_fetch_tag = fetch_pc[15:6];
    assign w_hit       = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign pred_index  = w_fetch_idx;
    assign pred_taken  = w_hit && (r_uncond[w_fetch_idx] || branch_count[1]);
    assign next_pc     = pred_taken ? r_target[w_fetch_idx] : fetch_pc + 16'd2;

    // Resolution: a resolve with nothing in flight is dropped entirely.
    assign w_pop         = res_valid && !w_empty;
    assign w_res_idx     = res_pc[5:1];
    assign w_actual_next = (res_is_branch && res_taken) ? res_target : res_pc + 16'd2;
    assign mispredict    = w_pop && (w_actual_next != w_head.pred_next);
    assign redirect_pc   = w_actual_next;

    assign upd_en    = w_pop && res_is_branch && res_is_cond;
    assign upd_index = w_res_idx;
    assign upd_taken = res_taken;

    // A pop that does not flush frees a slot this cycle, so a full FIFO can still accept.
    assign fetch_ready = !w_full || (w_pop && !mispredict);
    assign w_push      = fetch_valid && fetch_ready && !mispredict;

    assign w_push_data.pc        = fetch_pc;
    assign w_push_data.pred_next = next_pc;

    assign w_btb_write = w_pop && res_is_branch && res_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_btb_write) begin
            r_valid[w_res_idx]  <= 1'b1;
            r_uncond[w_res_idx] <= !res_is_cond;
        end
    end

    // Tag and target contents are qualified by r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_btb_write) begin
            r_tag[w_res_idx]    <= res_pc[15:6];
            r_target[w_res_idx] <= res_target;
        end
    end

    pred_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (mispredict),
        .head      (w_head),
        .count     (w_unused_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // The head PC and the counter's hysteresis bit are carried but not needed here.
    assign w_unused_bits = ^{w_head.pc, branch_count[0], w_unused_count};

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [4:0]  pred_index;
    logic [1:0]  branch_count;
    logic        pred_taken;
    logic [15:0] next_pc;
    logic        res_valid;
    logic [15:0] res_pc;
    logic        res_is_branch;
    logic        res_is_cond;
    logic        res_taken;
    logic [15:0] res_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        upd_en;
    logic [4:0]  upd_index;
    logic        upd_taken;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .pred_index    (pred_index),
        .branch_count  (branch_count),
        .pred_taken    (pred_taken),
        .next_pc       (next_pc),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_is_branch (res_is_branch),
        .res_is_cond   (res_is_cond),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .upd_en        (upd_en),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken)
    );

    task automatic idle();
        fetch_valid   = 1'b0;
        res_valid     = 1'b0;
        res_pc        = 16'h0000;
        res_is_branch = 1'b0;
        res_is_cond   = 1'b0;
        res_taken     = 1'b0;
        res_target    = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [15:0] pc, input logic br, input logic cond,
                           input logic tk, input logic [15:0] tgt);
        res_valid     = 1'b1;
        res_pc        = pc;
        res_is_branch = br;
        res_is_cond   = cond;
        res_taken     = tk;
        res_target    = tgt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        fetch_pc = 16'h0000;
        branch_count = 2'b00;
        step();
        step();
        reset = 1'b0;
        #1;
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (upd_en !== 1'b0) begin n_err++; $display("FAIL reset_upd_en got=%b exp=0", upd_en); end
        resolve(16'h3000, 1'b1, 1'b1, 1'b1, 16'h1234);
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL empty_res_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (upd_en !== 1'b0) begin n_err++; $display("FAIL empty_res_upd_en got=%b exp=0", upd_en); end
        step();
        idle();
    endtask

    task automatic test_cold_miss();
        fetch_pc = 16'h3000; fetch_valid = 1'b1; branch_count = 2'b11;
        #1;
        n_vec++; if (pred_index !== 5'd0) begin n_err++; $display("FAIL cold_index got=%h exp=00", pred_index); end
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL cold_taken got=%b exp=0", pred_taken); end
        n_vec++; if (next_pc !== 16'h3002) begin n_err++; $display("FAIL cold_next got=%h exp=3002", next_pc); end
        step();
        idle();
        resolve(16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);
        #1;
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL cold_mispredict got=%b exp=1", mispredict); end
        n_vec++; if (redirect_pc !== 16'h3040) begin n_err++; $display("FAIL cold_redirect got=%h exp=3040", redirect_pc); end
        n_vec++; if ({upd_en, upd_index, upd_taken} !== {1'b1, 5'd0, 1'b1}) begin
            n_err++; $display("FAIL cold_update got=%b/%h/%b exp=1/00/1", upd_en, upd_index, upd_taken); end
        step();
        idle();
    endtask

    task automatic test_warm_hit();
        fetch_pc = 16'h3000; fetch_valid = 1'b1; branch_count = 2'b10;
        #1;
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL warm_taken got=%b exp=1", pred_taken); end
        n_vec++; if (next_pc !== 16'h3040) begin n_err++; $display("FAIL warm_next got=%h exp=3040", next_pc); end
        step();
        idle();
        resolve(16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL warm_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (upd_en !== 1'b1) begin n_err++; $display("FAIL warm_upd_en got=%b exp=1", upd_en); end
        // Back-to-back: next fetch pushes in the same cycle as this pop.
        fetch_pc = 16'h3000; fetch_valid = 1'b1; branch_count = 2'b01;
        #1;
        n_vec++; if (next_pc !== 16'h3002) begin n_err++; $display("FAIL weak_next got=%h exp=3002", next_pc); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", fetch_ready); end
        step();
        idle();
        resolve(16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);
        #1;
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL weak_mispredict got=%b exp=1", mispredict); end
        n_vec++; if (redirect_pc !== 16'h3040) begin n_err++; $display("FAIL weak_redirect got=%h exp=3040", redirect_pc); end
        step();
        idle();
    endtask

    task automatic test_tag_alias();
        fetch_pc = 16'h3040; branch_count = 2'b11;
        #1;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_taken got=%b exp=0", pred_taken); end
        n_vec++; if (next_pc !== 16'h3042) begin n_err++; $display("FAIL alias_next got=%h exp=3042", next_pc); end
    endtask

    task automatic test_unconditional();
        fetch_pc = 16'h4010; fetch_valid = 1'b1; branch_count = 2'b00;
        #1;
        n_vec++; if (next_pc !== 16'h4012) begin n_err++; $display("FAIL jmp_cold_next got=%h exp=4012", next_pc); end
        step();
        idle();
        resolve(16'h4010, 1'b1, 1'b0, 1'b1, 16'h5000);
        #1;
        n_vec++; if (upd_en !== 1'b0) begin n_err++; $display("FAIL jmp_upd_en got=%b exp=0", upd_en); end
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL jmp_mispredict got=%b exp=1", mispredict); end
        step();
        idle();
        fetch_pc = 16'h4010; branch_count = 2'b00;
        #1;
        n_vec++; if (pred_index !== 5'd8) begin n_err++; $display("FAIL jmp_index got=%h exp=08", pred_index); end
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jmp_taken got=%b exp=1", pred_taken); end
        n_vec++; if (next_pc !== 16'h5000) begin n_err++; $display("FAIL jmp_next got=%h exp=5000", next_pc); end
    endtask

    task automatic test_wrap();
        fetch_pc = 16'hFFFE; branch_count = 2'b11;
        #1;
        n_vec++; if (pred_index !== 5'd31) begin n_err++; $display("FAIL wrap_index got=%h exp=1f", pred_index); end
        n_vec++; if (next_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_next got=%h exp=0000", next_pc); end
    endtask

    task automatic test_fifo();
        branch_count = 2'b00;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 16'h1000 + 16'(2 * i);
            #1;
            n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, fetch_ready); end
            step();
        end
        fetch_pc = 16'h1008;
        #1;
        n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", fetch_ready); end
        resolve(16'h1000, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL full_pop_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready got=%b exp=1", fetch_ready); end
        step();
        idle();
        fetch_valid = 1'b1; fetch_pc = 16'h100A;
        #1;
        n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL still_full_ready got=%b exp=0", fetch_ready); end
        resolve(16'h1002, 1'b1, 1'b1, 1'b1, 16'h2000);
        #1;
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL flush_mispredict got=%b exp=1", mispredict); end
        n_vec++; if (redirect_pc !== 16'h2000) begin n_err++; $display("FAIL flush_redirect got=%h exp=2000", redirect_pc); end
        n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", fetch_ready); end
        step();
        idle();
        resolve(16'h1004, 1'b1, 1'b1, 1'b1, 16'h2222);
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL post_flush_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (upd_en !== 1'b0) begin n_err++; $display("FAIL post_flush_upd_en got=%b exp=0", upd_en); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL post_flush_ready got=%b exp=1", fetch_ready); end
        step();
        idle();
    endtask

    task automatic test_reset_midflight();
        branch_count = 2'b11;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 16'h1000 + 16'(2 * i);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got=%b exp=1", fetch_ready); end
        fetch_pc = 16'h3000;
        #1;
        n_vec++; if (next_pc !== 16'h3002) begin n_err++; $display("FAIL mid_reset_3000 got=%h exp=3002", next_pc); end
        fetch_pc = 16'h4010; branch_count = 2'b00;
        #1;
        n_vec++; if (next_pc !== 16'h4012) begin n_err++; $display("FAIL mid_reset_4010 got=%h exp=4012", next_pc); end
        resolve(16'h1000, 1'b1, 1'b1, 1'b1, 16'h7000);
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL mid_reset_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (upd_en !== 1'b0) begin n_err++; $display("FAIL mid_reset_upd_en got=%b exp=0", upd_en); end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_warm_hit();
        test_tag_alias();
        test_unconditional();
        test_wrap();
        test_fifo();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-stage neighbour of the bimodal counter array (branch_predictors).
- Drives the counter read index from the fetch PC and combines the returned 2-bit count with a direct-mapped BTB lookup to produce the predicted next PC.
- Tracks each fetched instruction's prediction in an in-order FIFO until the EX stage resolves it, then flags mispredicts, supplies the redirect PC, writes BTB entries and issues counter-update requests.

Parameters:
- ENTRIES, 32: BTB entries; must equal 2^$bits(lc3b_p_index) so the index matches the counter array.
- FIFO_DEPTH, 4: maximum in-flight predictions; power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fetch_pc  in  16  lc3b_word, PC being fetched
- fetch_valid  in  1  fetch stage presents an instruction
- fetch_ready  out  1  high when the FIFO can accept (count < FIFO_DEPTH, or a non-mispredict pop this cycle)
- pred_index  out  5  lc3b_p_index = fetch_pc[5:1], read index to the counter array
- branch_count  in  2  counter value returned for pred_index (combinational)
- pred_taken  out  1  prediction for fetch_pc
- next_pc  out  16  predicted next fetch PC
- res_valid  in  1  oldest in-flight instruction resolves this cycle
- res_pc  in  16  its PC
- res_is_branch  in  1  instruction is a control transfer
- res_is_cond  in  1  conditional BR (vs JMP/JSR/TRAP)
- res_taken  in  1  actual direction
- res_target  in  16  actual target
- mispredict  out  1  flush request, combinational, same cycle as res_valid
- redirect_pc  out  16  correct next PC when mispredict
- upd_en  out  1  counter update strobe
- upd_index  out  5  lc3b_p_index = res_pc[5:1]
- upd_taken  out  1  direction for counter update

Behaviour:
- Lookup, combinational:
  - idx = fetch_pc[5:1]; tag = fetch_pc[15:6].
  - hit = valid[idx] && tag_arr[idx] == tag.
  - pred_taken = hit && (uncond[idx] || branch_count[1]).
  - next_pc = pred_taken ? target_arr[idx] : fetch_pc + 2. The add is 16-bit and wraps, so 0xFFFE -> 0x0000.
- Push:
  - Fires when fetch_valid && fetch_ready && !mispredict.
  - Entry stored = {pc, pred_next = next_pc}.
- Pop:
  - Fires when res_valid && count != 0.
  - res_valid with an empty FIFO is ignored: no mispredict, no update. Bench assertion flags it.
- Compare:
  - actual_next = (res_is_branch && res_taken) ? res_target : res_pc + 2.
  - mispredict = pop && actual_next != head.pred_next.
  - redirect_pc = actual_next. It is always driven; it is meaningful only when mispredict = 1.
- Mispredict: next cycle the FIFO is empty (count = 0, pointers = 0). A push in the same cycle is suppressed.
- Push and pop in the same cycle without mispredict: count unchanged, allowed even when full.
- BTB write, registered, visible next cycle:
  - On pop && res_is_branch && res_taken: valid <= 1, tag <= res_pc[15:6], target <= res_target, uncond <= !res_is_cond.
  - Not-taken resolutions leave the entry untouched.
- Same-cycle lookup and write to one index: lookup sees old contents.
- Counter update:
  - upd_en = pop && res_is_branch && res_is_cond.
  - upd_index = res_pc[5:1]; upd_taken = res_taken.
  - Combinational; the counter array applies it on the same edge.
- Reset:
  - All valid bits 0. FIFO empty, pointers 0.
  - mispredict/upd_en 0. fetch_ready is 1 after the reset edge.
  - Target/tag arrays need no reset. Counter array state is not touched.
  - Reset mid-operation discards in-flight entries with no update or redirect.
- Latency: prediction 0 cycles; BTB write 1 cycle; flush effect on FIFO 1 cycle.

Decomposition:
- lc3b_types additions:
  - lc3b_btb_tag (10 bits).
  - struct lc3b_pred_entry {lc3b_word pc; lc3b_word pred_next;}.
  - Constant PRED_FIFO_DEPTH = 4.
  - Reuse lc3b_p_index and lc3b_word.
- One sub-module: pred_fifo, a synchronous FIFO of lc3b_pred_entry with push, pop, flush, count, full, empty. BTB arrays and compare logic stay in the top.

Test Plan:
- Cold miss: after reset, fetch_pc = 0x3000, branch_count = 2'b11 -> pred_taken = 0, next_pc = 0x3002. Resolve with res_is_branch = 1, res_is_cond = 1, res_taken = 1, res_target = 0x3040 -> mispredict = 1, redirect_pc = 0x3040, upd_en = 1, upd_index = 0, upd_taken = 1.
- Warm hit: fetch 0x3000 again with branch_count = 2'b10 -> pred_taken = 1, next_pc = 0x3040. Taken resolution -> mispredict = 0. Repeat with branch_count = 2'b01 -> next_pc = 0x3002.
- Tag alias: train 0x3000 -> 0x3040, then fetch 0x3040 (same idx 0, tag 0x0C1 vs 0x0C0) -> miss, next_pc = 0x3042.
- Unconditional: resolve JMP at 0x4010 -> 0x5000 (res_is_cond = 0) -> upd_en = 0. Later fetch 0x4010 with branch_count = 2'b00 -> pred_taken = 1, next_pc = 0x5000.
- FIFO: four pushes with no resolve -> fetch_ready = 0. Fifth fetch with res_valid and no mispredict -> accepted, count stays 4. Mispredict while fetch_valid = 1 -> no push, count = 0 next cycle.
- Reset mid-flight: 3 entries queued, assert reset one cycle -> fetch_ready = 1, previously trained PCs miss, res_valid next cycle is ignored.
